// File: rtl/pred_update_ctrl.sv
// rtl/pred_update_ctrl.sv - write-side controller for the 2-bit branch-prediction counter table
module pred_update_ctrl #(
  parameter int         IDX_W      = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          clear_req,
  input  logic                          req0_valid,
  input  logic [31:0]                   req0_pc,
  input  logic                          req0_taken,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [31:0]                   req1_pc,
  input  logic                          req1_taken,
  output logic                          req1_ready,
  output logic                          tbl_rd_en,
  output logic [IDX_W-1:0]              tbl_rd_idx,
  input  logic [1:0]                    tbl_rd_data,
  output logic                          tbl_wr_en,
  output logic [IDX_W-1:0]              tbl_wr_idx,
  output logic [1:0]                    tbl_wr_data,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] walk_idx;
  logic [IDX_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             rr_last;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             rd_pending;
  logic [1:0]       rd_data_q;
  logic [1:0]       cur_val, new_val;
  logic             full, empty, active;
  logic             grant0, grant1, push, pop;
  logic [IDX_W:0]   push_data;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{req0_pc[31:IDX_W+2], req0_pc[1:0], req1_pc[31:IDX_W+2], req1_pc[1:0]};

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign active     = rdy & ~rst & ~clear_req;
  assign fifo_count = count;
  assign init_done  = (state != S_INIT);

  // Grants see only the occupancy at cycle start; a same-cycle pop never frees a slot.
  assign grant0 = active & ~full & req0_valid & (~req1_valid | rr_last);
  assign grant1 = active & ~full & req1_valid & (~req0_valid | ~rr_last);
  assign push   = grant0 | grant1;
  assign push_data = grant0 ? {req0_pc[IDX_W+1:2], req0_taken} : {req1_pc[IDX_W+1:2], req1_taken};
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign {head_idx, head_taken} = fifo_mem[rd_ptr];
  assign pop = active & (state == S_IDLE) & ~empty;

  // Read data is only on the bus the cycle after the strobe; hold a copy across rdy stalls.
  assign cur_val = rd_pending ? tbl_rd_data : rd_data_q;

  always_comb begin
    new_val = cur_val;
    if (upd_taken && cur_val != 2'b11)       new_val = cur_val + 2'd1;
    else if (!upd_taken && cur_val != 2'b00) new_val = cur_val - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)                 state <= S_INIT;
    else if (rdy) begin
      if (clear_req)         state <= S_INIT;
      else                   state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (&walk_idx) state_nxt = S_IDLE;
      S_IDLE:  if (!empty)    state_nxt = S_UPD;
      S_UPD:                  state_nxt = S_IDLE;
      default:                state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    tbl_wr_en   = 1'b0;
    tbl_wr_idx  = walk_idx;
    tbl_wr_data = INIT_VAL;
    tbl_rd_en   = 1'b0;
    tbl_rd_idx  = head_idx;
    case (state)
      S_INIT: tbl_wr_en = active;
      S_IDLE: tbl_rd_en = pop;
      S_UPD: begin
        tbl_wr_en   = active;
        tbl_wr_idx  = upd_idx;
        tbl_wr_data = new_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      walk_idx  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_last   <= 1'b1;
      upd_idx   <= '0;
      upd_taken <= 1'b0;
    end else if (rdy && clear_req) begin
      walk_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (rdy) begin
      if (state == S_INIT) walk_idx <= walk_idx + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        upd_idx   <= head_idx;
        upd_taken <= head_taken;
      end
      count <= count + CW'(push) - CW'(pop);
      if (push && req0_valid && req1_valid) rr_last <= grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_pending <= 1'b0;
    else     rd_pending <= tbl_rd_en;
    if (rd_pending) rd_data_q <= tbl_rd_data;
  end

endmodule

// File: tb/tb_pred_update_ctrl.sv
// tb/tb_pred_update_ctrl.sv - directed bench for pred_update_ctrl with a behavioural counter table
module tb_pred_update_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear_req;
  logic        req0_valid, req0_taken, req0_ready;
  logic        req1_valid, req1_taken, req1_ready;
  logic [31:0] req0_pc, req1_pc;
  logic        tbl_rd_en, tbl_wr_en, init_done;
  logic [2:0]  tbl_rd_idx, tbl_wr_idx;
  logic [1:0]  tbl_rd_data, tbl_wr_data;
  logic [2:0]  fifo_count;

  logic [1:0]  tbl [8];
  logic        pre_en;
  logic [2:0]  pre_idx;
  logic [1:0]  pre_val;
  logic [4:0]  wlog [$];
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  pred_update_ctrl #(.IDX_W(3), .FIFO_DEPTH(4), .INIT_VAL(2'b01)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_req(clear_req),
    .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_taken(req0_taken), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_taken(req1_taken), .req1_ready(req1_ready),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_idx(tbl_rd_idx), .tbl_rd_data(tbl_rd_data),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_data(tbl_wr_data),
    .init_done(init_done), .fifo_count(fifo_count)
  );

  // Counter RAM: one-cycle read latency, output held between reads.
  always @(posedge clk) begin
    if (pre_en)         tbl[pre_idx] <= pre_val;
    else if (tbl_wr_en) tbl[tbl_wr_idx] <= tbl_wr_data;
    if (tbl_rd_en) tbl_rd_data <= tbl[tbl_rd_idx];
  end

  always @(negedge clk) if (tbl_wr_en) wlog.push_back({tbl_wr_idx, tbl_wr_data});

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic e0 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic e1 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [2:0] ec [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};

  initial begin
    rst = 1'b1; rdy = 1'b1; clear_req = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    req0_valid = 1'b1; req0_pc = '0; req0_taken = 1'b0;
    req1_valid = 1'b0; req1_pc = '0; req1_taken = 1'b0;

    // reset cycle
    step(); settle();
    chk("rst_wr_en", tbl_wr_en, 0);
    chk("rst_rd_en", tbl_rd_en, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_count", fifo_count, 0);

    // init walk
    step(); rst = 1'b0; req0_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      settle();
      chk($sformatf("init_wr_en_%0d", i), tbl_wr_en, 1);
      chk($sformatf("init_idx_%0d", i), tbl_wr_idx, i);
      chk($sformatf("init_data_%0d", i), tbl_wr_data, 2'b01);
      chk($sformatf("init_done_lo_%0d", i), init_done, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("idle_wr_en", tbl_wr_en, 0);
      chk("idle_rd_en", tbl_rd_en, 0);
      chk("idle_init_done", init_done, 1);
    end

    // req0 pc=0x10 taken x3 -> idx4 saturates
    wlog.delete();
    for (int k = 0; k < 3; k++) begin
      step(); req0_valid = 1'b1; req0_pc = 32'h10; req0_taken = 1'b1;
      settle(); chk("t2_ready0", req0_ready, 1);
    end
    step(); req0_valid = 1'b0;
    repeat (8) step();
    settle();
    chk("t2_nwrites", wlog.size(), 3);
    chk("t2_w0", wlog[0], {3'd4, 2'b10});
    chk("t2_w1", wlog[1], {3'd4, 2'b11});
    chk("t2_w2", wlog[2], {3'd4, 2'b11});

    // both requesters: alternating grants until full
    wlog.delete();
    for (int k = 0; k < 8; k++) begin
      step();
      req0_valid = 1'b1; req0_pc = 32'h4;  req0_taken = 1'b1;
      req1_valid = 1'b1; req1_pc = 32'h18; req1_taken = 1'b0;
      settle();
      chk($sformatf("t3_count_%0d", k), fifo_count, ec[k]);
      chk($sformatf("t3_ready0_%0d", k), req0_ready, e0[k]);
      chk($sformatf("t3_ready1_%0d", k), req1_ready, e1[k]);
    end
    step(); req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (12) step();
    settle();
    chk("t3_nwrites", wlog.size(), 7);
    chk("t3_w0", wlog[0], {3'd1, 2'b10});
    chk("t3_w1", wlog[1], {3'd6, 2'b00});
    chk("t3_w6", wlog[6], {3'd1, 2'b11});
    chk("t3_drained", fifo_count, 0);

    // not-taken on a counter already at 00
    step(); pre_en = 1'b1; pre_idx = 3'd2; pre_val = 2'b00;
    step(); pre_en = 1'b0;
    wlog.delete();
    req1_valid = 1'b1; req1_pc = 32'h8; req1_taken = 1'b0;
    settle(); chk("t4_ready1", req1_ready, 1);
    step(); req1_valid = 1'b0;
    repeat (5) step();
    settle();
    chk("t4_nwrites", wlog.size(), 1);
    chk("t4_w0", wlog[0], {3'd2, 2'b00});

    // rdy low for 5 cycles in UPD
    wlog.delete();
    step(); req0_valid = 1'b1; req0_pc = 32'hC; req0_taken = 1'b1;
    settle(); chk("t5_ready0_a", req0_ready, 1);
    step(); settle(); chk("t5_ready0_b", req0_ready, 1);
    step(); req0_valid = 1'b0; rdy = 1'b0; req1_valid = 1'b1; req1_pc = 32'h0;
    for (int f = 0; f < 5; f++) begin
      settle();
      chk($sformatf("t5_frz_wr_%0d", f), tbl_wr_en, 0);
      chk($sformatf("t5_frz_rd_%0d", f), tbl_rd_en, 0);
      chk($sformatf("t5_frz_rdy1_%0d", f), req1_ready, 0);
      chk($sformatf("t5_frz_cnt_%0d", f), fifo_count, 1);
      step();
    end
    rdy = 1'b1; req1_valid = 1'b0;
    settle();
    chk("t5_resume_wr", tbl_wr_en, 1);
    chk("t5_resume_idx", tbl_wr_idx, 3);
    chk("t5_resume_data", tbl_wr_data, 2'b10);
    repeat (4) step();
    settle();
    chk("t5_nwrites", wlog.size(), 2);
    chk("t5_w1", wlog[1], {3'd3, 2'b11});

    // clear_req during UPD with 3 queued
    for (int k = 0; k < 6; k++) begin
      step(); req0_valid = 1'b1; req0_pc = 32'h14; req0_taken = 1'b1;
      settle(); chk($sformatf("t6_ready0_%0d", k), req0_ready, 1);
    end
    step(); clear_req = 1'b1;
    settle();
    chk("t6_clr_count", fifo_count, 3);
    chk("t6_clr_wr", tbl_wr_en, 0);
    chk("t6_clr_ready0", req0_ready, 0);
    step(); clear_req = 1'b0; req0_valid = 1'b0;
    settle();
    chk("t6_count0", fifo_count, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin step(); settle(); end
      chk($sformatf("t6_init_done_%0d", i), init_done, 0);
      chk($sformatf("t6_wr_en_%0d", i), tbl_wr_en, 1);
      chk($sformatf("t6_idx_%0d", i), tbl_wr_idx, i);
      chk($sformatf("t6_data_%0d", i), tbl_wr_data, 2'b01);
    end
    step(); settle();
    chk("t6_done_wr", tbl_wr_en, 0);
    chk("t6_done", init_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
